// File: rtl/wb_pulpino_ctrl_pkg.sv
// Shared definitions for the pulpino control block: register offsets, CTRL bit
// positions, reset-sequencer state encoding and a byte-lane write helper.
package wb_pulpino_ctrl_pkg;

  // Register offsets within the 256-byte window
  localparam logic [7:0] CTRL_OFF    = 8'h00;
  localparam logic [7:0] STATUS_OFF  = 8'h04;
  localparam logic [7:0] GPIO_OFF    = 8'h08;
  localparam logic [7:0] EDGE_OFF    = 8'h0C;
  localparam logic [7:0] IRQ_EN_OFF  = 8'h10;
  localparam logic [7:0] RST_LEN_OFF = 8'h14;

  // CTRL bit positions
  localparam int unsigned CTRL_RST_REQ  = 0;
  localparam int unsigned CTRL_FETCH_EN = 1;
  localparam int unsigned CTRL_CLK_SEL  = 2;
  localparam int unsigned CTRL_TESTMODE = 3;

  // Settle time between core reset release and fetch permission
  localparam int unsigned HOLD_CYCLES = 4;

  typedef enum logic [1:0] {
    StAssert = 2'd0,
    StHold   = 2'd1,
    StIdle   = 2'd2
  } rst_state_e;

  // Merge write data into an old value under Wishbone byte enables
  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_pulpino_ctrl_rst_seq.sv
// Core reset sequencer: holds the core in reset for a programmable number of
// cycles, then waits a fixed settle time before reporting idle.
// Ports: clk_i, rst_i (sync, active high), start_i (restart pulse),
//        len_i (assert length, sampled with start_i), core_rst_n_o, busy_o.
module wb_pulpino_ctrl_rst_seq
  import wb_pulpino_ctrl_pkg::*;
#(
  parameter logic [15:0] RstLenDefault = 16'd64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] len_i,
  output logic        core_rst_n_o,
  output logic        busy_o
);

  rst_state_e  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        core_rst_n_q, core_rst_n_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (start_i) begin
      state_d = StAssert;
      count_d = len_i;
    end else begin
      case (state_q)
        // Length N keeps reset low for N cycles; a length of 0 still gives one
        StAssert: begin
          if (count_q <= 16'd1) begin
            state_d = StHold;
            count_d = 16'(HOLD_CYCLES - 1);
          end else begin
            count_d = count_q - 16'd1;
          end
        end
        StHold: begin
          if (count_q == 16'd0) state_d = StIdle;
          else                  count_d = count_q - 16'd1;
        end
        StIdle:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    core_rst_n_d = (state_d != StAssert);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StAssert;
      count_q      <= RstLenDefault;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign core_rst_n_o = core_rst_n_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: rtl/wb_pulpino_ctrl.sv
// Wishbone classic slave controlling pulpino_top from the management SoC:
// core reset stretching, boot straps, synchronised GPIO with sticky
// rising-edge flags and a maskable interrupt.
// Ports: wb_clk_i/wb_rst_i (sync, active high); wbs_* Wishbone slave;
//        gpio_i (async core GPIO); core_rst_n_o, fetch_enable_o, clk_sel_o,
//        testmode_o straps to the core; user_irq_o to the management core.
module wb_pulpino_ctrl
  import wb_pulpino_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter logic [15:0] RST_LEN_DEFAULT = 16'd64,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [31:0] gpio_i,
  output logic        core_rst_n_o,
  output logic        fetch_enable_o,
  output logic        clk_sel_o,
  output logic        testmode_o,
  output logic        user_irq_o
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        fetch_en_q, fetch_en_d;
  logic        clk_sel_q, clk_sel_d;
  logic        testmode_q, testmode_d;
  logic [31:0] edge_q, edge_d;
  logic [31:0] irq_en_q, irq_en_d;
  logic [15:0] rst_len_q, rst_len_d;
  logic        fetch_enable_q, fetch_enable_d;
  logic        user_irq_q, user_irq_d;
  logic [SYNC_STAGES-1:0][31:0] sync_q, sync_d;
  logic [31:0] gpio_d_q;

  logic        hit, wr, rst_start, rst_busy;
  logic [31:0] gpio_s, rise, edge_clr, rdata;

  // ack_q in the hit term makes held strobes alternate ack 1,0,1,...
  assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
  assign wr  = hit & wbs_we_i;

  assign gpio_s = sync_q[SYNC_STAGES-1];
  assign rise   = gpio_s & ~gpio_d_q;
  assign sync_d = {sync_q[SYNC_STAGES-2:0], gpio_i};

  assign rst_start = wr & (wbs_adr_i[7:0] == CTRL_OFF) & wbs_sel_i[0] & wbs_dat_i[CTRL_RST_REQ];

  always_comb begin
    fetch_en_d = fetch_en_q;
    clk_sel_d  = clk_sel_q;
    testmode_d = testmode_q;
    irq_en_d   = irq_en_q;
    rst_len_d  = rst_len_q;
    edge_clr   = '0;
    if (wr) begin
      case (wbs_adr_i[7:0])
        CTRL_OFF: begin
          if (wbs_sel_i[0]) begin
            fetch_en_d = wbs_dat_i[CTRL_FETCH_EN];
            clk_sel_d  = wbs_dat_i[CTRL_CLK_SEL];
            testmode_d = wbs_dat_i[CTRL_TESTMODE];
          end
        end
        EDGE_OFF:   edge_clr = wbs_dat_i & apply_sel(32'h0, 32'hFFFF_FFFF, wbs_sel_i);
        IRQ_EN_OFF: irq_en_d = apply_sel(irq_en_q, wbs_dat_i, wbs_sel_i);
        RST_LEN_OFF: begin
          if (wbs_sel_i[0]) rst_len_d[7:0]  = wbs_dat_i[7:0];
          if (wbs_sel_i[1]) rst_len_d[15:8] = wbs_dat_i[15:8];
        end
        default: ;
      endcase
    end
    // A rise in the same cycle as its W1C clear keeps the flag set
    edge_d         = (edge_q & ~edge_clr) | rise;
    user_irq_d     = |(edge_q & irq_en_q);
    fetch_enable_d = fetch_en_q & ~rst_busy;
  end

  always_comb begin
    rdata = '0;
    case (wbs_adr_i[7:0])
      CTRL_OFF: begin
        rdata[CTRL_FETCH_EN] = fetch_en_q;
        rdata[CTRL_CLK_SEL]  = clk_sel_q;
        rdata[CTRL_TESTMODE] = testmode_q;
      end
      STATUS_OFF:  rdata = {29'b0, user_irq_q, fetch_enable_q, rst_busy};
      GPIO_OFF:    rdata = gpio_s;
      EDGE_OFF:    rdata = edge_q;
      IRQ_EN_OFF:  rdata = irq_en_q;
      RST_LEN_OFF: rdata = {16'b0, rst_len_q};
      default:     rdata = '0;
    endcase
    ack_d = hit;
    dat_d = (hit & ~wbs_we_i) ? rdata : '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q          <= 1'b0;
      dat_q          <= '0;
      fetch_en_q     <= 1'b0;
      clk_sel_q      <= 1'b0;
      testmode_q     <= 1'b0;
      edge_q         <= '0;
      irq_en_q       <= '0;
      rst_len_q      <= RST_LEN_DEFAULT;
      fetch_enable_q <= 1'b0;
      user_irq_q     <= 1'b0;
      sync_q         <= '0;
      gpio_d_q       <= '0;
    end else begin
      ack_q          <= ack_d;
      dat_q          <= dat_d;
      fetch_en_q     <= fetch_en_d;
      clk_sel_q      <= clk_sel_d;
      testmode_q     <= testmode_d;
      edge_q         <= edge_d;
      irq_en_q       <= irq_en_d;
      rst_len_q      <= rst_len_d;
      fetch_enable_q <= fetch_enable_d;
      user_irq_q     <= user_irq_d;
      sync_q         <= sync_d;
      gpio_d_q       <= gpio_s;
    end
  end

  // Same-cycle RST_LEN write is honoured by feeding the next-state length
  wb_pulpino_ctrl_rst_seq #(
    .RstLenDefault(RST_LEN_DEFAULT)
  ) u_rst_seq (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .start_i     (rst_start),
    .len_i       (rst_len_d),
    .core_rst_n_o(core_rst_n_o),
    .busy_o      (rst_busy)
  );

  assign wbs_ack_o      = ack_q;
  assign wbs_dat_o      = dat_q;
  assign fetch_enable_o = fetch_enable_q;
  assign clk_sel_o      = clk_sel_q;
  assign testmode_o     = testmode_q;
  assign user_irq_o     = user_irq_q;

endmodule

// File: tb/tb_wb_pulpino_ctrl.sv
module tb_wb_pulpino_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int unsigned SYNC = 2;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] gpio_i = '0;
  logic        core_rst_n_o, fetch_enable_o, clk_sel_o, testmode_o, user_irq_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wb_pulpino_ctrl dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (wb_rst_i),
    .wbs_cyc_i     (wbs_cyc_i),
    .wbs_stb_i     (wbs_stb_i),
    .wbs_we_i      (wbs_we_i),
    .wbs_sel_i     (wbs_sel_i),
    .wbs_adr_i     (wbs_adr_i),
    .wbs_dat_i     (wbs_dat_i),
    .wbs_ack_o     (wbs_ack_o),
    .wbs_dat_o     (wbs_dat_o),
    .gpio_i        (gpio_i),
    .core_rst_n_o  (core_rst_n_o),
    .fetch_enable_o(fetch_enable_o),
    .clk_sel_o     (clk_sel_o),
    .testmode_o    (testmode_o),
    .user_irq_o    (user_irq_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge where ack is seen
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata);
    logic got;
    int   n;
    got = 1'b0;
    n = 0;
    rdata = '0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    while (!got && n < 4) begin
      @(negedge clk);
      n++;
      if (wbs_ack_o) begin
        got = 1'b1;
        rdata = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    check($sformatf("ack@%08h", adr), {31'b0, got}, 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] unused;
    wb_xfer(1'b1, BASE + off, dat, sel, unused);
  endtask

  task automatic wb_read(input logic [31:0] off, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    wb_xfer(1'b0, BASE + off, 32'h0, 4'hF, rd);
    check(name, rd, exp);
  endtask

  task automatic count_low(output int cnt);
    cnt = 0;
    while (core_rst_n_o == 1'b0 && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    int acks;

    vecs[0]  = '{1'b1, 32'h10, 4'hF, 32'hA5A5_5A5A, 32'h0};
    vecs[1]  = '{1'b0, 32'h10, 4'hF, 32'h0,         32'hA5A5_5A5A};
    vecs[2]  = '{1'b1, 32'h10, 4'h4, 32'h0012_0000, 32'h0};
    vecs[3]  = '{1'b0, 32'h10, 4'hF, 32'h0,         32'hA512_5A5A};
    vecs[4]  = '{1'b1, 32'h10, 4'hF, 32'h0,         32'h0};
    vecs[5]  = '{1'b0, 32'h10, 4'hF, 32'h0,         32'h0};
    vecs[6]  = '{1'b1, 32'h14, 4'hF, 32'hDEAD_0033, 32'h0};
    vecs[7]  = '{1'b0, 32'h14, 4'hF, 32'h0,         32'h0000_0033};
    vecs[8]  = '{1'b1, 32'h14, 4'h1, 32'hFFFF_FF10, 32'h0};
    vecs[9]  = '{1'b0, 32'h14, 4'hF, 32'h0,         32'h0000_0010};
    vecs[10] = '{1'b1, 32'h08, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{1'b0, 32'h08, 4'hF, 32'h0,         32'h0};
    vecs[12] = '{1'b1, 32'h04, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[13] = '{1'b0, 32'h04, 4'hF, 32'h0,         32'h0};
    vecs[14] = '{1'b1, 32'h40, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[15] = '{1'b0, 32'h40, 4'hF, 32'h0,         32'h0};
    vecs[16] = '{1'b0, 32'h18, 4'hF, 32'h0,         32'h0};
    vecs[17] = '{1'b1, 32'h00, 4'hF, 32'h0000_000C, 32'h0};
    vecs[18] = '{1'b0, 32'h00, 4'hF, 32'h0,         32'h0000_000C};
    vecs[19] = '{1'b1, 32'h00, 4'h2, 32'hFFFF_FFFF, 32'h0};
    vecs[20] = '{1'b0, 32'h00, 4'hF, 32'h0,         32'h0000_000C};
    vecs[21] = '{1'b1, 32'h00, 4'hF, 32'h0,         32'h0};
    vecs[22] = '{1'b0, 32'h00, 4'hF, 32'h0,         32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_core_rst_n", {31'b0, core_rst_n_o}, 32'd0);
    check("rst_fetch", {31'b0, fetch_enable_o}, 32'd0);
    check("rst_irq", {31'b0, user_irq_o}, 32'd0);
    check("rst_straps", {30'b0, clk_sel_o, testmode_o}, 32'd0);

    // Power-on stretch
    wb_rst_i = 1'b0;
    count_low(cnt);
    check("por_low_cycles", cnt, 64);
    wb_read(32'h04, 32'h1, "status_hold");
    repeat (6) @(negedge clk);
    wb_read(32'h04, 32'h0, "status_idle");
    check("por_fetch", {31'b0, fetch_enable_o}, 32'd0);

    // Register table
    for (int i = 0; i < 23; i++) begin
      if (vecs[i].we) wb_write(vecs[i].adr, vecs[i].dat, vecs[i].sel);
      else            wb_read(vecs[i].adr, vecs[i].exp, $sformatf("vec%0d", i));
    end
    wb_write(32'h00, 32'hC, 4'hF);
    check("straps_set", {30'b0, clk_sel_o, testmode_o}, 32'd3);
    wb_write(32'h00, 32'h0, 4'hF);
    check("straps_clr", {30'b0, clk_sel_o, testmode_o}, 32'd0);

    // FETCH_EN and a short software reset
    wb_write(32'h00, 32'h2, 4'hF);
    check("fetch_on_ack", {31'b0, fetch_enable_o}, 32'd0);
    @(negedge clk);
    check("fetch_after_ack", {31'b0, fetch_enable_o}, 32'd1);
    wb_read(32'h00, 32'h2, "ctrl_rd");
    wb_write(32'h14, 32'h5, 4'hF);
    wb_write(32'h00, 32'h3, 4'hF);
    count_low(cnt);
    check("req5_low_cycles", cnt, 5);
    check("req5_fetch_low", {31'b0, fetch_enable_o}, 32'd0);
    wb_read(32'h04, 32'h1, "req5_status_busy");
    repeat (8) @(negedge clk);
    check("req5_fetch_idle", {31'b0, fetch_enable_o}, 32'd1);
    wb_read(32'h04, 32'h2, "req5_status_idle");
    wb_read(32'h00, 32'h2, "ctrl_req_reads0");

    // GPIO edge capture and interrupt
    gpio_i = 32'h8;
    repeat (3) @(negedge clk);
    wb_read(32'h0C, 32'h8, "edge_set");
    wb_write(32'h10, 32'h8, 4'hF);
    check("irq_latency", {31'b0, user_irq_o}, 32'd0);
    @(negedge clk);
    check("irq_on", {31'b0, user_irq_o}, 32'd1);
    wb_read(32'h08, 32'h8, "gpio_rd");
    wb_write(32'h0C, 32'h8, 4'hF);
    @(negedge clk);
    check("irq_off", {31'b0, user_irq_o}, 32'd0);
    wb_read(32'h0C, 32'h0, "edge_w1c");
    gpio_i = 32'h0;
    repeat (5) @(negedge clk);
    wb_read(32'h0C, 32'h0, "edge_fall_ignored");
    gpio_i = 32'h8;
    repeat (SYNC) @(negedge clk);
    wb_write(32'h0C, 32'h8, 4'hF);
    wb_read(32'h0C, 32'h8, "edge_set_wins");
    @(negedge clk);
    check("irq_again", {31'b0, user_irq_o}, 32'd1);

    // Held strobe: ack alternates
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_adr_i = BASE + 32'h08;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("b2b_ack%0d", i), {31'b0, wbs_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("b2b_dat%0d", i), wbs_dat_o, (i % 2 == 0) ? 32'h8 : 32'h0);
    end
    wbs_adr_i = BASE + 32'h100;
    @(negedge clk);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wbs_ack_o) acks++;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check("outside_no_ack", acks, 0);
    @(negedge clk);

    // RST_REQ restart mid-ASSERT, then bus reset during HOLD
    wb_write(32'h14, 32'h40, 4'hF);
    wb_write(32'h00, 32'h3, 4'hF);
    repeat (9) @(negedge clk);
    check("mid_assert", {31'b0, core_rst_n_o}, 32'd0);
    wb_write(32'h00, 32'h3, 4'hF);
    count_low(cnt);
    check("restart_low_cycles", cnt, 64);
    @(negedge clk);
    gpio_i = 32'h0;
    wb_rst_i = 1'b1;
    repeat (2) @(negedge clk);
    check("hold_rst_core", {31'b0, core_rst_n_o}, 32'd0);
    check("hold_rst_fetch", {31'b0, fetch_enable_o}, 32'd0);
    check("hold_rst_irq", {31'b0, user_irq_o}, 32'd0);
    check("hold_rst_ack", {31'b0, wbs_ack_o}, 32'd0);
    wb_rst_i = 1'b0;
    count_low(cnt);
    check("hold_rst_low_cycles", cnt, 64);
    wb_read(32'h04, 32'h1, "hold_rst_status");
    wb_read(32'h00, 32'h0, "hold_rst_ctrl");
    wb_read(32'h10, 32'h0, "hold_rst_irq_en");
    wb_read(32'h14, 32'h40, "hold_rst_len");
    wb_read(32'h0C, 32'h0, "hold_rst_edge");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_pulpino_ctrl.md
Name: wb_pulpino_ctrl

Overview:
- Wishbone classic slave between the management SoC bus (wbs_*) and pulpino_top inside the user project wrapper.
- Generates the stretched core reset and drives the fetch_enable, clk_sel and testmode straps.
- Synchronises the core's 32-bit gpio_out, records sticky rising edges, and raises user_irq[0].
- Gives firmware on the management core control of core boot and visibility of core GPIO.

Parameters:
BASE_ADDR, 32'h3000_0000, register window base; decode compares adr[31:8] only
RST_LEN_DEFAULT, 16'd64, reset-stretch length in wb_clk_i cycles, loaded at wb_rst_i
SYNC_STAGES, 2, flop depth of the gpio_i synchroniser (legal range 2..3)

Ports:
wb_clk_i  in  1  single clock for the whole block
wb_rst_i  in  1  synchronous, active-high reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte enables
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
gpio_i  in  32  pulpino_top gpio_out; asynchronous to wb_clk_i
core_rst_n_o  out  1  to pulpino_top rst_n
fetch_enable_o  out  1  to fetch_enable_i
clk_sel_o  out  1  to clk_sel_i
testmode_o  out  1  to testmode_i
user_irq_o  out  1  to user_irq[0]

Behaviour:
Register map (offset from BASE_ADDR, word-aligned):
- 0x00 CTRL, RW: [0] RST_REQ (write-1 pulse, always reads 0); [1] FETCH_EN; [2] CLK_SEL; [3] TESTMODE.
- 0x04 STATUS, RO: [0] rst_busy; [1] fetch_enable_o; [2] user_irq_o.
- 0x08 GPIO, RO: synchronised gpio_i.
- 0x0C EDGE, W1C: sticky rising-edge flags.
- 0x10 IRQ_EN, RW: per-bit mask.
- 0x14 RST_LEN, RW: [15:0], upper bits read 0.

Wishbone bus:
- Hit = cyc & stb & (adr[31:8] == BASE_ADDR[31:8]) & !ack.
- ack is registered, asserted the cycle after a hit, high for exactly 1 cycle. Read/write latency is 1 cycle.
- With stb held across consecutive transfers, ack toggles 1,0,1,...
- Writes are byte-masked by wbs_sel_i and take effect on the ack cycle.
- Unmapped offsets inside the window: ack, read 0, write ignored. Outside the window: no ack.
- wbs_dat_o is 0 whenever ack is low.

Reset values:
- ack 0, dat_o 0.
- CTRL: FETCH_EN 0, CLK_SEL 0, TESTMODE 0.
- EDGE 0, IRQ_EN 0, RST_LEN = RST_LEN_DEFAULT.
- Synchroniser flops 0; core_rst_n_o 0; fetch_enable_o 0; user_irq_o 0.

Reset sequencer FSM (ASSERT, HOLD, IDLE):
- wb_rst_i forces ASSERT with count = RST_LEN (power-on stretch).
- ASSERT: core_rst_n_o = 0; count decrements each cycle; at count 0 go to HOLD.
- HOLD: core_rst_n_o = 1; 4 cycles, then IDLE. Lets the core settle before fetch.
- IDLE: core_rst_n_o = 1.
- A RST_REQ write in any state reloads count from the current RST_LEN value (including the same-cycle write of RST_LEN if both are written) and enters ASSERT. A RST_REQ write during ASSERT therefore restarts the count.
- RST_LEN = 0: ASSERT lasts 1 cycle.
- rst_busy = (state != IDLE).
- fetch_enable_o = FETCH_EN & (state == IDLE), registered.

GPIO path:
- gpio_i passes through SYNC_STAGES flops to give gpio_s, plus 1 extra flop to give gpio_d.
- rise = gpio_s & ~gpio_d.
- EDGE[i] sets on rise[i] and clears on a write-1 to bit i. Set wins when both happen in the same cycle.
- Edge detection runs regardless of core reset state.
- user_irq_o = |(EDGE & IRQ_EN), registered (1-cycle latency).

Decomposition:
- Package wb_pulpino_ctrl_pkg holds:
  - register offset localparams (CTRL_OFF, STATUS_OFF, GPIO_OFF, EDGE_OFF, IRQ_EN_OFF, RST_LEN_OFF);
  - CTRL bit indices;
  - the sequencer state enum (ASSERT, HOLD, IDLE);
  - HOLD_CYCLES = 4.
- Sub-module rst_seq: the FSM plus 16-bit counter. Inputs: start pulse, length. Outputs: core_rst_n, busy.
- Bus decode, register file and GPIO sync/edge logic stay in the top module.

Test Plan:
1. Release wb_rst_i -> core_rst_n_o stays low for 64 cycles, high thereafter; STATUS reads 0x0 after 68 cycles; fetch_enable_o stays 0.
2. Write CTRL=0x2, then read CTRL -> reads 0x2; fetch_enable_o=1 one cycle after the write ack. Then write RST_LEN=5 and CTRL=0x3 -> core_rst_n_o low for 5 cycles, fetch_enable_o low until IDLE, reread STATUS[0]=1 during the sequence.
3. Drive gpio_i[3] 0->1 -> EDGE reads 0x8 within SYNC_STAGES+2 cycles. With IRQ_EN=0x8, user_irq_o=1. Write EDGE=0x8 -> EDGE=0, irq=0. Repeat with the rise landing on the W1C cycle -> EDGE stays 0x8.
4. Hold stb/cyc high for back-to-back reads of GPIO -> ack pattern 1,0,1; dat_o 0 on non-ack cycles. Address 0x3000_0040 -> ack, data 0. Address 0x3000_0100 -> no ack for 10 cycles.
5. Byte-masked write RST_LEN sel=4'b0001 data 0xFFFF_FF10 -> RST_LEN reads 0x0010 (upper byte of the default 0x0040 is already 0, so bits [15:8] stay 0x00).
6. Issue RST_REQ at cycle 10 of a 64-cycle ASSERT -> counter restarts; core_rst_n_o low for 64 further cycles. Assert wb_rst_i mid-HOLD -> all registers return to reset values, FSM in ASSERT.
